interrupt_arbiter: RTL and testbench

//  Consumes the latched pending vector from the interrupt storage stage and applies
//  the CP0 gating: Status.IM mask, IE, EXL and ERL. Priority-encodes the result and

---
 rtl/interrupt_arbiter_if.sv | 33 +++
 rtl/interrupt_arbiter.sv | 112 +++++++++++
 tb/tb_interrupt_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/interrupt_arbiter_if.sv
// Bundle between the interrupt arbiter and its surroundings: gated pending inputs,
// CP0 status bits, and the request/ack handshake to the pipeline exception unit.
interface interrupt_arbiter_if #(
  parameter int N    = 8,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    pending;
  logic [N-1:0]    im;
  logic            ie;
  logic            exl;
  logic            erl;
  logic            ack;
  logic            eret;
  logic            req;
  logic [ID_W-1:0] req_id;
  logic [N-1:0]    req_cause;
  logic            storage_clear;
  logic            busy;
  logic [1:0]      state;

  // Handshake: req is the valid, ack is the acceptance. While req=1, req_id and
  // req_cause are frozen; the transfer happens in the cycle where req=1 and ack=1.
  // req may be withdrawn without ack only when the gated pending set goes empty.
  modport master (
    output pending, im, ie, exl, erl, ack, eret,
    input  req, req_id, req_cause, storage_clear, busy, state
  );

  modport slave (
    input  pending, im, ie, exl, erl, ack, eret,
    output req, req_id, req_cause, storage_clear, busy, state
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// Applies CP0 gating to the latched pending vector, priority-encodes it and runs the
// req/ack handshake with a storage clear pulse and a post-ERET hold-off window.
module interrupt_arbiter #(
  parameter int N       = 8,
  parameter int HOLDOFF = 2,
  parameter int ID_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  interrupt_arbiter_if.slave irq
);
  localparam int CNT_W = (HOLDOFF + 1 <= 2) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            req_q;
  logic [ID_W-1:0] req_id_q;
  logic [N-1:0]    req_cause_q;
  logic            clear_q;
  logic            busy_q;

  logic [N-1:0]    masked;
  logic            gate;
  logic            fire;

  assign masked = irq.pending & irq.im;
  assign gate   = irq.ie & ~irq.exl & ~irq.erl;
  assign fire   = gate & (|masked);

  // Highest set index wins; an empty vector encodes as 0.
  function automatic logic [ID_W-1:0] prio(input logic [N-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= 1'b0;
      req_id_q    <= '0;
      req_cause_q <= '0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            state       <= REQ;
            req_q       <= 1'b1;
            req_cause_q <= masked;
            req_id_q    <= prio(masked);
            busy_q      <= 1'b1;
          end
        end
        REQ: begin
          // ack takes precedence over a simultaneous loss of fire.
          if (irq.ack) begin
            state   <= SERVICE;
            req_q   <= 1'b0;
            clear_q <= 1'b1;
          end else if (!fire) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq.eret) begin
            if (HOLDOFF == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= HOLD;
              cnt   <= CNT_W'(HOLDOFF);
            end
          end
        end
        HOLD: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq.req           = req_q;
  assign irq.req_id        = req_id_q;
  assign irq.req_cause     = req_cause_q;
  assign irq.storage_clear = clear_q;
  assign irq.busy          = busy_q;
  assign irq.state         = state;
endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a behavioural model through an expected-output queue.
module tb_interrupt_arbiter;
  localparam int N       = 8;
  localparam int HOLDOFF = 2;
  localparam int ID_W    = $clog2(N);
  localparam int OW      = N + ID_W + 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interrupt_arbiter_if #(.N(N), .ID_W(ID_W)) irq_if();

  interrupt_arbiter #(.N(N), .HOLDOFF(HOLDOFF), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .irq   (irq_if.slave)
  );

  // scoreboard: {req, req_id, req_cause, storage_clear, busy} expected after each edge
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: request outstanding, handler running, hold-off cycles remaining
  bit           m_req;
  bit           m_svc;
  bit           m_clr;
  int           m_hold;
  logic [N-1:0] m_cause;
  int           m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Predict the outcome of the coming edge from the current inputs, then advance.
  task automatic cycle();
    logic [N-1:0] masked;
    bit           fire;
    masked = irq_if.pending & irq_if.im;
    fire   = irq_if.ie && !irq_if.exl && !irq_if.erl && (masked != '0);
    m_clr  = 1'b0;
    if (reset) begin
      m_req = 0; m_svc = 0; m_hold = 0; m_cause = '0; m_id = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_svc) begin
      if (irq_if.eret) begin
        m_svc  = 0;
        m_hold = HOLDOFF;
      end
    end else if (m_req) begin
      if (irq_if.ack) begin
        m_req = 0; m_svc = 1; m_clr = 1;
      end else if (!fire) begin
        m_req = 0;
      end
    end else if (fire) begin
      m_req   = 1;
      m_cause = masked;
      m_id    = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (masked[i]) begin
          m_id = i;
          break;
        end
      end
    end
    exp_q.push_back({m_req, ID_W'(m_id), m_cause, m_clr, (m_req || m_svc || m_hold > 0)});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] p, input logic [N-1:0] m, input logic e,
                       input logic x, input logic r, input logic a, input logic t);
    irq_if.pending = p; irq_if.im = m; irq_if.ie = e; irq_if.exl = x;
    irq_if.erl = r; irq_if.ack = a; irq_if.eret = t;
  endtask

  // monitor: one output sample per edge, popped on the opposite edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      logic [OW-1:0] a;
      e = exp_q.pop_front();
      a = {irq_if.req, irq_if.req_id, irq_if.req_cause, irq_if.storage_clear, irq_if.busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got {req,id,cause,clr,busy}=%h expected %h", $time, a, e);
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    chk("reset_req", irq_if.req, 0);
    chk("reset_busy", irq_if.busy, 0);
    reset = 1'b0;

    // basic request and its snapshot
    drive(8'h14, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("t1_req", irq_if.req, 1);
    chk("t1_id", irq_if.req_id, 4);
    chk("t1_cause", irq_if.req_cause, 8'h14);
    chk("t1_busy", irq_if.busy, 1);

    // ack, one clear pulse, then eret with hold-off
    irq_if.ack = 1'b1; cycle(); irq_if.ack = 1'b0;
    chk("t2_req_after_ack", irq_if.req, 0);
    chk("t2_clear", irq_if.storage_clear, 1);
    cycle();
    chk("t2_clear_once", irq_if.storage_clear, 0);
    irq_if.pending = 8'h01; irq_if.eret = 1'b1; cycle(); irq_if.eret = 1'b0;
    cycle(); chk("t2_hold1", irq_if.req, 0);
    cycle(); chk("t2_hold2", irq_if.req, 0);
    cycle(); chk("t2_req_after_hold", irq_if.req, 1);
    chk("t2_id0", irq_if.req_id, 0);
    irq_if.ack = 1'b1; cycle(); irq_if.ack = 1'b0;
    irq_if.pending = '0; irq_if.eret = 1'b1; cycle(); irq_if.eret = 1'b0;
    cycle(); cycle(); cycle();

    // masked line, then unmasked
    drive(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    chk("t3_masked", irq_if.req, 0);
    irq_if.im = 8'hFF; cycle();
    chk("t3_req", irq_if.req, 1);
    chk("t3_id7", irq_if.req_id, 7);

    // withdraw on exl, then exl together with ack
    irq_if.exl = 1'b1; cycle();
    chk("t4_withdraw_req", irq_if.req, 0);
    chk("t4_withdraw_clr", irq_if.storage_clear, 0);
    chk("t4_withdraw_busy", irq_if.busy, 0);
    irq_if.exl = 1'b0; cycle();
    chk("t4_rereq", irq_if.req, 1);
    irq_if.exl = 1'b1; irq_if.ack = 1'b1; cycle(); irq_if.ack = 1'b0;
    chk("t4_ack_wins_clr", irq_if.storage_clear, 1);
    chk("t4_ack_wins_busy", irq_if.busy, 1);

    // reset in SERVICE, in HOLD, and with a clear pulse in flight
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("t5_rst_service_busy", irq_if.busy, 0);
    irq_if.exl = 1'b0; cycle();
    irq_if.ack = 1'b1; cycle(); irq_if.ack = 1'b0;
    irq_if.eret = 1'b1; cycle(); irq_if.eret = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("t5_rst_hold_busy", irq_if.busy, 0);
    chk("t5_rst_hold_cause", irq_if.req_cause, 0);
    cycle();
    irq_if.ack = 1'b1; reset = 1'b1; cycle(); reset = 1'b0; irq_if.ack = 1'b0;
    chk("t5_rst_drops_clear", irq_if.storage_clear, 0);
    irq_if.pending = '0; irq_if.ack = 1'b1; irq_if.eret = 1'b1;
    cycle(); cycle();
    chk("t5_idle_ack_eret", irq_if.busy, 0);

    // randomized traffic
    for (int k = 0; k < 10000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      irq_if.pending = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      irq_if.im      = ($urandom_range(0, 3) == 0) ? N'($urandom) : {N{1'b1}};
      irq_if.ie      = ($urandom_range(0, 7) != 0);
      irq_if.exl     = ($urandom_range(0, 9) == 0);
      irq_if.erl     = ($urandom_range(0, 15) == 0);
      irq_if.ack     = ($urandom_range(0, 3) == 0);
      irq_if.eret    = ($urandom_range(0, 3) == 0);
      cycle();
    end

    reset = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
